disp_mux_n: RTL and testbench

Parametrised time-multiplexing driver for common-anode/cathode 7-segment LED displays, and the next generation of the 4-digit `disp_mux`. It scans N digits from a flattened pattern bus and adds per-digit blanking, 16-level PWM brightness, and a selectable pad polarity. It provides a frame-start strobe for upstream display logic. It sits between the display-data registers (reaction-timer readout) and the FPGA anode/segment pads.

---
 rtl/disp_mux_n.sv | 123 ++++++++++++
 tb/tb_disp_mux_n.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/disp_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : disp_mux_n
// Description : N-digit time-multiplexed 7-segment display driver with
//               per-digit blanking, 16-level PWM brightness, selectable pad
//               polarity and a frame-start strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_mux_n #(
    parameter int N_DIGITS    = 4,
    parameter int SLOT_CYCLES = 65536,
    parameter int ACTIVE_LOW  = 1,
    localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*N_DIGITS-1:0]   in,
    input  logic [N_DIGITS-1:0]     blank,
    input  logic [3:0]              bright,
    output logic [N_DIGITS-1:0]     an,
    output logic [7:0]              sseg,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);

    // Pad-level "off" values depend on the board's drive polarity.
    localparam logic [N_DIGITS-1:0] c_off_an    = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]          c_off_seg   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam int                  c_phase_len = SLOT_CYCLES / 16;

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [3:0]          r_bright_q;
    logic [N_DIGITS-1:0] r_an;
    logic [7:0]          r_sseg;
    logic                r_frame_tick;

    logic                w_last_cnt;
    logic                w_last_idx;
    logic                w_frame_start;
    logic [7:0]          w_seg_sel;
    logic                w_blank_sel;
    logic [31:0]         w_on_cycles;
    logic                w_lit;
    logic [N_DIGITS-1:0] w_an_next;

    assign w_last_cnt    = (r_cnt == CNT_W'(SLOT_CYCLES - 1));
    assign w_last_idx    = (r_idx == IDX_W'(N_DIGITS - 1));
    assign w_frame_start = (r_cnt == '0) && (r_idx == '0);

    // Slot counter and digit index; index advances on each slot wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_last_cnt) begin
            r_cnt <= '0;
            r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Brightness is captured only at frame start so a frame is never mixed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bright_q <= 4'hF;
        end else if (w_frame_start) begin
            r_bright_q <= bright;
        end
    end

    // Select the current digit's pattern and blank bit without a variable
    // part-select, so the index never needs range widening.
    always_comb begin
        w_seg_sel   = in[7:0];
        w_blank_sel = blank[0];
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_seg_sel   = in[8*k +: 8];
                w_blank_sel = blank[k];
            end
        end
    end

    // phase <= bright_q is the same as cnt < (bright_q+1)*PHASE_LEN, which
    // avoids a divider for non power-of-two slot lengths.
    assign w_on_cycles = (32'(r_bright_q) + 32'd1) * 32'(c_phase_len);
    assign w_lit       = !w_blank_sel && (32'(r_cnt) < w_on_cycles);

    // One-hot anode drive: only the current digit may be asserted.
    always_comb begin
        w_an_next = c_off_an;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (w_lit && (r_idx == IDX_W'(k))) begin
                w_an_next[k] = ~c_off_an[k];
            end
        end
    end

    // Registered pad drive and frame strobe; segments are off whenever the
    // anodes are off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an         <= c_off_an;
            r_sseg       <= c_off_seg;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= w_an_next;
            r_sseg       <= w_lit ? w_seg_sel : c_off_seg;
            r_frame_tick <= w_last_cnt && w_last_idx;
        end
    end

    assign an         = r_an;
    assign sseg       = r_sseg;
    assign frame_tick = r_frame_tick;
    assign digit_idx  = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_disp_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_mux_n
// Description : Directed self-checking bench for disp_mux_n. Instance u_dut
//               is 4 digits / 16-cycle slots / active-low; instance u_dut1
//               is 1 digit / 16-cycle slots / active-high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_mux_n;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] din    = 32'h8699A4C0;
    logic [3:0]  blank  = 4'b0000;
    logic [3:0]  bright = 4'hF;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    logic [7:0]  din1    = 8'h5B;
    logic        blank1  = 1'b0;
    logic [3:0]  bright1 = 4'hF;
    logic        an1;
    logic [7:0]  sseg1;
    logic        digit_idx1;
    logic        frame_tick1;

    int          checks   = 0;
    int          failures = 0;
    int          cur_k    = 0;
    logic [7:0]  pat [4];

    disp_mux_n #(.N_DIGITS(4), .SLOT_CYCLES(16), .ACTIVE_LOW(1)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in         (din),
        .blank      (blank),
        .bright     (bright),
        .an         (an),
        .sseg       (sseg),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    disp_mux_n #(.N_DIGITS(1), .SLOT_CYCLES(16), .ACTIVE_LOW(0)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .in         (din1),
        .blank      (blank1),
        .bright     (bright1),
        .an         (an1),
        .sseg       (sseg1),
        .digit_idx  (digit_idx1),
        .frame_tick (frame_tick1)
    );

    // Free-running clock: rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s k=%0d observed=0x%0h expected=0x%0h", tag, cur_k, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_an",    32'(an),          32'hF);
        chk("rst_sseg",  32'(sseg),        32'hFF);
        chk("rst_ftick", 32'(frame_tick),  32'd0);
        chk("rst_idx",   32'(digit_idx),   32'd0);
        chk("rst_an1",   32'(an1),         32'd0);
        chk("rst_sseg1", 32'(sseg1),       32'h00);
        chk("rst_ftick1",32'(frame_tick1), 32'd0);
        chk("rst_idx1",  32'(digit_idx1),  32'd0);
    endtask

    // k = rising edges since reset release; outputs now reflect state k-1
    // and digit_idx reflects state k.
    task automatic check_cycle(input int k, input bit lit);
        int         j;
        int         d;
        logic [3:0] ea;
        logic [7:0] es;
        j     = k - 1;
        d     = (j / 16) % 4;
        cur_k = k;
        ea    = 4'hF;
        es    = 8'hFF;
        if (lit) begin
            ea[d] = 1'b0;
            es    = pat[d];
        end
        chk("an",         32'(an),          32'(ea));
        chk("sseg",       32'(sseg),        32'(es));
        chk("frame_tick", 32'(frame_tick),  32'((k % 64) == 0));
        chk("digit_idx",  32'(digit_idx),   32'((k / 16) % 4));
        chk("an1",        32'(an1),         32'd1);
        chk("sseg1",      32'(sseg1),       32'h5B);
        chk("frame_tick1",32'(frame_tick1), 32'((k % 16) == 0));
        chk("digit_idx1", 32'(digit_idx1),  32'd0);
    endtask

    initial begin
        pat[0] = 8'hC0;
        pat[1] = 8'hA4;
        pat[2] = 8'h99;
        pat[3] = 8'h86;

        // Asynchronous reset between clock edges.
        #2 reset = 1'b0;
        #1 check_reset_state();
        repeat (5) begin
            @(negedge clk);
            check_reset_state();
        end
        reset = 1'b1;

        // Full-brightness scan over two frames.
        for (int k = 1; k <= 128; k++) begin
            @(negedge clk);
            check_cycle(k, 1'b1);
        end

        // Dimming: bright=3 from the frame starting at state 128.
        bright = 4'd3;
        for (int k = 129; k <= 192; k++) begin
            @(negedge clk);
            check_cycle(k, ((k - 1) % 16) <= 3);
        end

        // Minimum brightness: one lit cycle per slot.
        bright = 4'd0;
        for (int k = 193; k <= 256; k++) begin
            @(negedge clk);
            check_cycle(k, ((k - 1) % 16) == 0);
        end

        // Blank digit 2, then clear it mid-slot (state 357 = digit 2, cnt 5).
        bright = 4'hF;
        blank  = 4'b0100;
        for (int k = 257; k <= 384; k++) begin
            @(negedge clk);
            check_cycle(k, ((((k - 1) / 16) % 4) != 2) || ((k - 1) >= 357));
            if (k == 357) blank = 4'b0000;
        end

        // Brightness 15 -> 0 during digit 1; takes effect next frame (state 448).
        for (int k = 385; k <= 512; k++) begin
            @(negedge clk);
            check_cycle(k, ((k - 1) < 448) || (((k - 1) % 16) == 0));
            if (k == 404) bright = 4'd0;
        end

        // Back to full brightness and run to idx=2, cnt=7.
        bright = 4'hF;
        for (int k = 513; k <= 551; k++) begin
            @(negedge clk);
            check_cycle(k, 1'b1);
        end

        // Asynchronous reset mid-slot: outputs dark with no clock edge.
        #2 reset = 1'b0;
        #1 check_reset_state();
        repeat (5) begin
            @(negedge clk);
            check_reset_state();
        end
        reset = 1'b1;

        // Scan restarts at digit 0; first frame_tick 64 cycles later.
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            check_cycle(k, 1'b1);
        end

        // Active-high single-digit instance: blanking drives all-zero pads.
        blank1 = 1'b1;
        @(negedge clk);
        chk("blank_an1",   32'(an1),   32'd0);
        chk("blank_sseg1", 32'(sseg1), 32'h00);
        blank1 = 1'b0;
        @(negedge clk);
        chk("unblank_an1",   32'(an1),   32'd1);
        chk("unblank_sseg1", 32'(sseg1), 32'h5B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
